inst_encoder_writer: RTL and testbench

Encodes instructions for the 3-stage core from decoded fields (opcode5, registers, functs, 32-bit immediate) back into 32-bit RV32I words. This is the inverse of the IF-stage immediate generation. Each word is streamed out with an auto-incrementing byte address to an IMEM/BIOS write port. It is used by the on-chip loader and by test infrastructure. It validates immediate range and alignment per format and buffers output behind a valid/ready handshake.

---
 rtl/inst_encoder_writer_pkg.sv | 41 ++++
 rtl/inst_encoder_writer_field_pack.sv | 75 +++++++
 rtl/inst_encoder_writer.sv | 131 +++++++++++++
 tb/tb_inst_encoder_writer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_writer_pkg.sv
// Shared constants for the RV32I instruction encoder/writer.
// Provides the 5-bit opcode class values (instruction[6:2]), the default
// filler word used for rejected requests, and the immediate range limits
// for each encoding format, plus a small signed range helper.
package inst_encoder_writer_pkg;

  // Opcode classes, instruction[6:2]
  localparam logic [4:0] OPC_LUI_5       = 5'b01101;
  localparam logic [4:0] OPC_AUIPC_5     = 5'b00101;
  localparam logic [4:0] OPC_JAL_5       = 5'b11011;
  localparam logic [4:0] OPC_JALR_5      = 5'b11001;
  localparam logic [4:0] OPC_BRANCH_5    = 5'b11000;
  localparam logic [4:0] OPC_STORE_5     = 5'b01000;
  localparam logic [4:0] OPC_LOAD_5      = 5'b00000;
  localparam logic [4:0] OPC_ARI_RTYPE_5 = 5'b01100;
  localparam logic [4:0] OPC_ARI_ITYPE_5 = 5'b00100;
  localparam logic [4:0] OPC_CSR_5       = 5'b11100;

  // funct3 values that turn an ARI_ITYPE into a shift-immediate
  localparam logic [2:0] FNC_SLL     = 3'b001;
  localparam logic [2:0] FNC_SRL_SRA = 3'b101;

  // addi x0,x0,0
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0013;

  // Immediate limits per format (inclusive)
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int SHAMT_MIN = 0;
  localparam int SHAMT_MAX = 31;
  localparam int BR_MIN    = -4096;
  localparam int BR_MAX    = 4094;
  localparam int JAL_MIN   = -1048576;
  localparam int JAL_MAX   = 1048574;

  function automatic logic in_range(input logic signed [31:0] v,
                                    input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/inst_encoder_writer_field_pack.sv
// inst_field_pack: combinational RV32I field packer.
// Builds the 32-bit instruction word from decoded fields and reports whether
// the immediate is legal for the selected format.
// Ports:
//   opcode5/rd/rs1/rs2/funct3/funct7/imm : decoded request fields
//   inst   : packed instruction (zero for an unknown opcode class)
//   imm_ok : immediate in range/aligned for the format (0 for unknown opcode)
module inst_field_pack
  import inst_encoder_writer_pkg::*;
(
  input  logic [4:0]  opcode5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        imm_ok
);

  logic signed [31:0] imm_s;
  logic [6:0]         opc7;

  assign imm_s = imm;
  assign opc7  = {opcode5, 2'b11};

  always_comb begin
    inst   = '0;
    imm_ok = 1'b0;
    case (opcode5)
      OPC_ARI_RTYPE_5: begin
        inst   = {funct7, rs2, rs1, funct3, rd, opc7};
        imm_ok = 1'b1;
      end
      OPC_ARI_ITYPE_5, OPC_LOAD_5, OPC_JALR_5: begin
        // Only the ALU class has shift-immediates; LH/LHU share funct3 codes
        if ((opcode5 == OPC_ARI_ITYPE_5) &&
            ((funct3 == FNC_SLL) || (funct3 == FNC_SRL_SRA))) begin
          inst   = {funct7, imm[4:0], rs1, funct3, rd, opc7};
          imm_ok = in_range(imm_s, SHAMT_MIN, SHAMT_MAX);
        end else begin
          inst   = {imm[11:0], rs1, funct3, rd, opc7};
          imm_ok = in_range(imm_s, IMM12_MIN, IMM12_MAX);
        end
      end
      OPC_STORE_5: begin
        inst   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opc7};
        imm_ok = in_range(imm_s, IMM12_MIN, IMM12_MAX);
      end
      OPC_BRANCH_5: begin
        inst   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opc7};
        imm_ok = in_range(imm_s, BR_MIN, BR_MAX) && !imm[0];
      end
      OPC_JAL_5: begin
        inst   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc7};
        imm_ok = in_range(imm_s, JAL_MIN, JAL_MAX) && !imm[0];
      end
      OPC_LUI_5, OPC_AUIPC_5: begin
        inst   = {imm[31:12], rd, opc7};
        imm_ok = (imm[11:0] == 12'h000);
      end
      OPC_CSR_5: begin
        // CSR number comes from {funct7,rs2}; the zimm lives in imm[4:0]
        inst   = {funct7, rs2, imm[4:0], funct3, rd, opc7};
        imm_ok = (imm[31:5] == 27'd0);
      end
      default: begin
        inst   = '0;
        imm_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder_writer.sv
// inst_encoder_writer: encodes decoded RV32I requests into instruction words
// and streams them with auto-incrementing byte addresses to an IMEM/BIOS
// write port through a 2-entry output buffer.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, start_addr : reload address, flush buffer, clear errors/count
//   in_valid/in_ready : request handshake; in_opcode5..in_imm request fields
//   out_valid/out_ready, out_addr, out_inst : write-port handshake and word
//   err_range, err_addr : sticky validation error and first failing address
//   count             : words transferred since reset/start, saturating
module inst_encoder_writer
  import inst_encoder_writer_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [31:0]       NOP_WORD  = DEFAULT_NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_inst,
  output logic              err_range,
  output logic [ADDR_W-1:0] err_addr,
  output logic [15:0]       count
);

  logic [31:0]       packed_inst;
  logic              imm_ok;
  logic [31:0]       enc_inst;
  logic [ADDR_W-1:0] addr_q;

  // Second buffer slot behind the output register
  logic              spill_vld;
  logic [ADDR_W-1:0] spill_addr;
  logic [31:0]       spill_inst;

  logic push, pop, full;
  logic head_from_in, head_from_spill, spill_load;

  inst_field_pack u_pack (
    .opcode5 (in_opcode5),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .funct3  (in_funct3),
    .funct7  (in_funct7),
    .imm     (in_imm),
    .inst    (packed_inst),
    .imm_ok  (imm_ok)
  );

  assign enc_inst = imm_ok ? packed_inst : NOP_WORD;

  assign full     = out_valid && spill_vld;
  assign in_ready = !rst && !start && !full;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Push is impossible while the spill slot is occupied (buffer full), so
  // these three load conditions never overlap.
  assign head_from_in    = push && (!out_valid || pop);
  assign head_from_spill = pop && spill_vld;
  assign spill_load      = push && out_valid && !pop;

  // ---- request accept -> output register / spill slot ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      spill_vld <= 1'b0;
      out_inst  <= '0;
      out_addr  <= BASE_ADDR;
      addr_q    <= BASE_ADDR;
      err_range <= 1'b0;
      err_addr  <= '0;
      count     <= '0;
    end else if (start) begin
      out_valid <= 1'b0;
      spill_vld <= 1'b0;
      addr_q    <= start_addr;
      err_range <= 1'b0;
      err_addr  <= '0;
      count     <= '0;
    end else begin
      if (push) begin
        addr_q <= addr_q + ADDR_W'(4);
        if (!imm_ok) begin
          err_range <= 1'b1;
          if (!err_range) err_addr <= addr_q;
        end
      end

      if (pop && (count != 16'hFFFF)) count <= count + 16'd1;

      if (head_from_spill) begin
        out_inst  <= spill_inst;
        out_addr  <= spill_addr;
        spill_vld <= 1'b0;
      end else if (head_from_in) begin
        out_inst  <= enc_inst;
        out_addr  <= addr_q;
        out_valid <= 1'b1;
      end else if (spill_load) begin
        spill_vld <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

  // ---- spill slot data (qualified by spill_vld) ----
  always_ff @(posedge clk) begin
    if (spill_load) begin
      spill_inst <= enc_inst;
      spill_addr <= addr_q;
    end
  end

endmodule

// File: tb/tb_inst_encoder_writer.sv
module tb_inst_encoder_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] start_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_opcode5 = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_addr;
  logic [31:0] out_inst;
  logic        err_range;
  logic [31:0] err_addr;
  logic [15:0] count;

  inst_encoder_writer #(
    .ADDR_W    (32),
    .BASE_ADDR (32'h0000_0000),
    .NOP_WORD  (32'h0000_0013)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode5 (in_opcode5),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_inst   (out_inst),
    .err_range  (err_range),
    .err_addr   (err_addr),
    .count      (count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference encoder: expected word straight from the field placement rules
  function automatic bit [31:0] ref_word(input bit [4:0] op, input bit [4:0] rd,
                                         input bit [4:0] rs1, input bit [4:0] rs2,
                                         input bit [2:0] f3, input bit [6:0] f7,
                                         input bit [31:0] imm, output bit ok);
    int s = imm;
    bit [31:0] w = 0;
    bit [31:0] common = 32'(rs1) << 15 | 32'(f3) << 12 | 32'(rd) << 7;
    ok = 0;
    case (op)
      5'b01100: begin
        w  = 32'(f7) << 25 | 32'(rs2) << 20 | common;
        ok = 1;
      end
      5'b00100, 5'b00000, 5'b11001: begin
        if (op == 5'b00100 && (f3 == 3'd1 || f3 == 3'd5)) begin
          w  = 32'(f7) << 25 | (imm % 32) << 20 | common;
          ok = (s >= 0) && (s <= 31);
        end else begin
          w  = (imm % 4096) << 20 | common;
          ok = (s >= -2048) && (s <= 2047);
        end
      end
      5'b01000: begin
        w  = ((imm >> 5) % 128) << 25 | 32'(rs2) << 20 | 32'(rs1) << 15 |
             32'(f3) << 12 | (imm % 32) << 7;
        ok = (s >= -2048) && (s <= 2047);
      end
      5'b11000: begin
        w  = ((imm >> 12) % 2) << 31 | ((imm >> 5) % 64) << 25 | 32'(rs2) << 20 |
             32'(rs1) << 15 | 32'(f3) << 12 | ((imm >> 1) % 16) << 8 |
             ((imm >> 11) % 2) << 7;
        ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
      end
      5'b11011: begin
        w  = ((imm >> 20) % 2) << 31 | ((imm >> 1) % 1024) << 21 |
             ((imm >> 11) % 2) << 20 | ((imm >> 12) % 256) << 12 | 32'(rd) << 7;
        ok = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
      end
      5'b01101, 5'b00101: begin
        w  = (imm / 4096) * 4096 | 32'(rd) << 7;
        ok = (imm % 4096) == 0;
      end
      5'b11100: begin
        w  = (32'(f7) * 32 + 32'(rs2)) << 20 | (imm % 32) << 15 | 32'(f3) << 12 |
             32'(rd) << 7;
        ok = imm < 32;
      end
      default: ok = 0;
    endcase
    return ok ? (w | 32'(op) * 4 + 3) : 32'h0000_0013;
  endfunction

  typedef struct {
    bit [31:0] addr;
    bit [31:0] inst;
  } word_t;

  word_t     exp_q[$];
  word_t     log_q[$];
  bit [31:0] m_addr     = 0;
  bit        m_err      = 0;
  bit [31:0] m_err_addr = 0;
  int        m_count    = 0;

  // Scoreboard: checks state left by the last edge, then applies this cycle
  always @(negedge clk) begin
    bit        exp_rdy, exp_vld, ok;
    bit [31:0] w;
    exp_rdy = !rst && !start && (exp_q.size() < 2);
    exp_vld = exp_q.size() != 0;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_vld);
    if (exp_vld) begin
      chk("out_addr", out_addr, exp_q[0].addr);
      chk("out_inst", out_inst, exp_q[0].inst);
    end
    chk("count", count, 16'(m_count));
    chk("err_range", err_range, m_err);
    chk("err_addr", err_addr, m_err_addr);
    if (rst) begin
      exp_q.delete();
      m_addr = 0; m_err = 0; m_err_addr = 0; m_count = 0;
    end else if (start) begin
      exp_q.delete();
      m_addr = start_addr; m_err = 0; m_err_addr = 0; m_count = 0;
    end else begin
      if (exp_vld && out_ready) begin
        log_q.push_back('{out_addr, out_inst});
        void'(exp_q.pop_front());
        if (m_count < 65535) m_count++;
      end
      if (in_valid && exp_rdy) begin
        w = ref_word(in_opcode5, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, ok);
        exp_q.push_back('{m_addr, w});
        if (!ok) begin
          if (!m_err) m_err_addr = m_addr;
          m_err = 1;
        end
        m_addr = m_addr + 4;
      end
    end
  end

  bit rand_rdy = 0;

  function automatic bit [63:0] log_at(input int i);
    if (i < log_q.size()) return {log_q[i].addr, log_q[i].inst};
    return '1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_start(input bit [31:0] a);
    start_addr = a;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input bit [4:0] op, input bit [4:0] rd, input bit [4:0] rs1,
                      input bit [4:0] rs2, input bit [2:0] f3, input bit [6:0] f7,
                      input bit [31:0] imm);
    int t = 0;
    bit acc = 0;
    in_opcode5 = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      t++;
    end while (!acc && t < 200);
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    out_ready = 1'b1;
    while (out_valid && t < 100) begin
      tick();
      t++;
    end
    chk("drain", out_valid, 0);
  endtask

  bit [4:0]  ops[11] = '{5'b01100, 5'b00100, 5'b00000, 5'b11001, 5'b01000, 5'b11000,
                         5'b11011, 5'b01101, 5'b00101, 5'b11100, 5'b11111};
  bit [31:0] imms[20] = '{32'd0, 32'd5, -32'sd4, 32'd2047, 32'd2048, -32'sd2048,
                          -32'sd2049, 32'd31, 32'd32, 32'd4094, 32'd4096, -32'sd4096,
                          32'd3, 32'h800, 32'd1048574, 32'd1048576, -32'sd1048576,
                          32'h1234_5000, 32'h1234_5001, -32'sd2};

  initial begin
    int base;
    bit [31:0] imm;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_addr", out_addr, 32'h0);

    // Basic I-type
    do_start(32'h1000);
    base = log_q.size();
    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    drain();
    chk("addi_word", log_at(base), {32'h1000, 32'h0050_0093});
    chk("count_one", count, 16'd1);

    // Store then branch
    do_start(32'h1000);
    base = log_q.size();
    send(5'b01000, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    send(5'b11000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
    drain();
    chk("store_word", log_at(base), {32'h1000, 32'h0020_A423});
    chk("branch_word", log_at(base + 1), {32'h1004, 32'hFE00_0EE3});

    // JAL, LUI, then two rejected requests
    do_start(32'h1000);
    base = log_q.size();
    send(5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
    send(5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    send(5'b11000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    drain();
    chk("jal_word", log_at(base), {32'h1000, 32'h0010_00EF});
    chk("lui_word", log_at(base + 1), {32'h1004, 32'h1234_52B7});
    chk("bad_imm12", log_at(base + 2), {32'h1008, 32'h0000_0013});
    chk("bad_branch", log_at(base + 3), {32'h100C, 32'h0000_0013});
    chk("err_set", err_range, 1'b1);
    chk("err_first", err_addr, 32'h1008);
    send(5'b00100, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    drain();
    chk("after_err", log_at(base + 4), {32'h1010, 32'h0010_0113});

    // Backpressure: third request stalls while output is held
    base = log_q.size();
    out_ready = 1'b0;
    send(5'b00100, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd10);
    send(5'b00100, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd11);
    fork
      send(5'b00100, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd12);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("full_ready", in_ready, 1'b0);
          chk("held_inst", out_inst, 32'h00A0_0193);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("drain0", log_at(base), {32'h1014, 32'h00A0_0193});
    chk("drain1", log_at(base + 1), {32'h1018, 32'h00B0_0213});
    chk("drain2", log_at(base + 2), {32'h101C, 32'h00C0_0293});

    // start while buffered and a request is pending
    out_ready = 1'b0;
    send(5'b00100, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    send(5'b00100, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    in_valid = 1'b1;
    in_opcode5 = 5'b00100; in_rd = 5'd8; in_imm = 32'd3;
    start_addr = 32'hFFFF_FFFC;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_err", err_range, 1'b0);
    chk("flush_count", count, 16'd0);
    base = log_q.size();
    out_ready = 1'b1;
    send(5'b00100, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    send(5'b00100, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    drain();
    chk("wrap0", log_at(base), {32'hFFFF_FFFC, 32'h0010_0493});
    chk("wrap1", log_at(base + 1), {32'h0000_0000, 32'h0020_0513});

    // Randomized traffic with random backpressure, restarts and resets
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 2))
        0: imm = imms[$urandom_range(0, 19)];
        1: imm = 32'($urandom_range(0, 63)) - 32'd32;
        default: imm = $urandom;
      endcase
      send(ops[$urandom_range(0, 10)], 5'($urandom), 5'($urandom), 5'($urandom),
           3'($urandom), 7'($urandom), imm);
      repeat ($urandom_range(0, 2)) tick();
      if ($urandom_range(0, 59) == 0) do_start($urandom & 32'hFFFF_FFFC);
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end
    rand_rdy = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    chk("watchdog", 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "simulation time limit reached");
  end

endmodule
